// File: rtl/pwd_lock_pkg.sv
// Shared state encoding and small helpers for the password-lock controller.
package pwd_lock_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_LOCKED  = 3'd1,
    ST_LOCKOUT = 3'd2,
    ST_OPEN    = 3'd3,
    ST_SETPW   = 3'd4
  } state_t;

  // Entry counter holds at 15 instead of wrapping back to a plausible count.
  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'd15) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/pwd_lock_ctrl_if.sv
// Command/digit strobes in, status out, between decoder, lock controller and display.
interface pwd_lock_ctrl_if
  import pwd_lock_pkg::*;
#(
  parameter int DIGIT_W = 8,
  parameter int TICK_W  = 8
);
  // Handshake: every strobe (tick, cmd_*, digit_vld) is a single-cycle pulse
  // sampled on the rising clk edge; there is no ready/backpressure, an event
  // the controller cannot use in its current state is simply dropped.
  logic               tick;
  logic               cmd_start;
  logic               cmd_check;
  logic               cmd_exit;
  logic               cmd_setpw;
  logic               digit_vld;
  logic [DIGIT_W-1:0] digit;

  logic [STATE_W-1:0] state;
  logic               unlocked;
  logic               err_pulse;
  logic               pw_changed;
  logic [3:0]         tries_left;
  logic [TICK_W-1:0]  lock_remain;
  logic [3:0]         entry_cnt;

  modport master (
    output tick, cmd_start, cmd_check, cmd_exit, cmd_setpw, digit_vld, digit,
    input  state, unlocked, err_pulse, pw_changed, tries_left, lock_remain, entry_cnt
  );

  modport slave (
    input  tick, cmd_start, cmd_check, cmd_exit, cmd_setpw, digit_vld, digit,
    output state, unlocked, err_pulse, pw_changed, tries_left, lock_remain, entry_cnt
  );

endinterface

// File: rtl/pwd_lock_ctrl_lock_timer.sv
// Lockout countdown: load to a fixed value, decrement per tick, flag the expiring tick.
module lock_timer #(
  parameter int TICK_W   = 8,
  parameter int LOAD_VAL = 60
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              tick,
  output logic [TICK_W-1:0] remain,
  output logic              done
);

  // done coincides with the tick that takes remain from 1 to 0.
  assign done = tick && (remain == TICK_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      remain <= '0;
    end else if (load) begin
      remain <= TICK_W'(LOAD_VAL);
    end else if (tick && (remain != '0)) begin
      remain <= remain - TICK_W'(1);
    end
  end

endmodule

// File: rtl/pwd_lock_ctrl.sv
// Password-lock controller: digit entry/check, retry limit, timed lockout, password change.
module pwd_lock_ctrl
  import pwd_lock_pkg::*;
#(
  parameter int                            DIGIT_W    = 8,
  parameter int                            N_DIGITS   = 3,
  parameter int                            MAX_TRIES  = 3,
  parameter int                            LOCK_TICKS = 60,
  parameter int                            TICK_W     = 8,
  parameter logic [N_DIGITS*DIGIT_W-1:0]   INIT_PW    = '0
) (
  input logic            clk,
  input logic            rst,
  pwd_lock_ctrl_if.slave bus
);

  localparam logic [3:0] N4   = 4'(N_DIGITS);
  localparam logic [3:0] MAX4 = 4'(MAX_TRIES);

  state_t             st, st_n;
  logic [3:0]         entry_cnt, entry_n;
  logic               mismatch, mism_n;
  logic               overflow, ovf_n;
  logic [3:0]         fails, fails_n;
  logic               err_q, err_n;
  logic               chg_q, chg_n;
  logic [DIGIT_W-1:0] stored_pw [N_DIGITS];
  logic [DIGIT_W-1:0] stored_n  [N_DIGITS];
  logic [DIGIT_W-1:0] shadow_pw [N_DIGITS];
  logic [DIGIT_W-1:0] shadow_n  [N_DIGITS];

  logic               timer_load;
  logic               timer_tick;
  logic               timer_done;
  logic [TICK_W-1:0]  timer_remain;

  logic               ev_exit, ev_check, ev_setpw, ev_digit;
  logic               in_range;
  logic [DIGIT_W-1:0] cur_digit;
  logic [3:0]         entry_inc;

  // One event per cycle: exit beats check beats setpw beats a digit.
  assign ev_exit  = bus.cmd_exit;
  assign ev_check = bus.cmd_check && !bus.cmd_exit;
  assign ev_setpw = bus.cmd_setpw && !bus.cmd_exit && !bus.cmd_check;
  assign ev_digit = bus.digit_vld && !bus.cmd_exit && !bus.cmd_check && !bus.cmd_setpw;

  assign in_range  = (entry_cnt < N4);
  assign entry_inc = sat_inc4(entry_cnt);

  always_comb begin
    cur_digit = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (entry_cnt == 4'(i)) cur_digit = stored_pw[i];
    end
  end

  assign timer_tick = bus.tick && (st == ST_LOCKOUT);

  lock_timer #(
    .TICK_W   (TICK_W),
    .LOAD_VAL (LOCK_TICKS)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (timer_load),
    .tick   (timer_tick),
    .remain (timer_remain),
    .done   (timer_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= ST_IDLE;
      entry_cnt <= '0;
      mismatch  <= 1'b0;
      overflow  <= 1'b0;
      fails     <= '0;
      err_q     <= 1'b0;
      chg_q     <= 1'b0;
      for (int i = 0; i < N_DIGITS; i++) begin
        stored_pw[i] <= INIT_PW[i*DIGIT_W +: DIGIT_W];
        shadow_pw[i] <= '0;
      end
    end else begin
      st        <= st_n;
      entry_cnt <= entry_n;
      mismatch  <= mism_n;
      overflow  <= ovf_n;
      fails     <= fails_n;
      err_q     <= err_n;
      chg_q     <= chg_n;
      stored_pw <= stored_n;
      shadow_pw <= shadow_n;
    end
  end

  always_comb begin
    st_n       = st;
    entry_n    = entry_cnt;
    mism_n     = mismatch;
    ovf_n      = overflow;
    fails_n    = fails;
    err_n      = 1'b0;
    chg_n      = 1'b0;
    timer_load = 1'b0;
    stored_n   = stored_pw;
    shadow_n   = shadow_pw;
    case (st)
      ST_IDLE: begin
        if (bus.cmd_start) st_n = ST_LOCKED;
      end
      ST_LOCKED: begin
        if (ev_check) begin
          entry_n = '0;
          mism_n  = 1'b0;
          if ((entry_cnt == N4) && !mismatch) begin
            st_n    = ST_OPEN;
            fails_n = '0;
          end else begin
            err_n   = 1'b1;
            fails_n = fails + 4'd1;
            if (fails_n == MAX4) begin
              st_n       = ST_LOCKOUT;
              timer_load = 1'b1;
            end
          end
        end else if (ev_digit) begin
          if (!in_range || (bus.digit != cur_digit)) mism_n = 1'b1;
          entry_n = entry_inc;
        end
      end
      ST_LOCKOUT: begin
        if (timer_done) begin
          st_n    = ST_LOCKED;
          fails_n = '0;
        end
      end
      ST_OPEN: begin
        if (ev_exit) begin
          st_n    = ST_LOCKED;
          entry_n = '0;
          mism_n  = 1'b0;
        end else if (ev_setpw) begin
          st_n    = ST_SETPW;
          entry_n = '0;
          ovf_n   = 1'b0;
          for (int i = 0; i < N_DIGITS; i++) shadow_n[i] = '0;
        end
      end
      ST_SETPW: begin
        if (ev_exit) begin
          st_n    = ST_OPEN;
          entry_n = '0;
          ovf_n   = 1'b0;
        end else if (ev_check) begin
          entry_n = '0;
          ovf_n   = 1'b0;
          if ((entry_cnt == N4) && !overflow) begin
            stored_n = shadow_pw;
            chg_n    = 1'b1;
            st_n     = ST_OPEN;
          end else begin
            err_n = 1'b1;
          end
        end else if (ev_digit) begin
          if (in_range) begin
            for (int i = 0; i < N_DIGITS; i++) begin
              if (entry_cnt == 4'(i)) shadow_n[i] = bus.digit;
            end
          end else begin
            ovf_n = 1'b1;
          end
          entry_n = entry_inc;
        end
      end
      default: st_n = ST_IDLE;
    endcase
  end

  assign bus.state       = st;
  assign bus.unlocked    = (st == ST_OPEN) || (st == ST_SETPW);
  assign bus.err_pulse   = err_q;
  assign bus.pw_changed  = chg_q;
  assign bus.tries_left  = MAX4 - fails;
  assign bus.lock_remain = timer_remain;
  assign bus.entry_cnt   = entry_cnt;

endmodule

// File: tb/tb_pwd_lock_ctrl.sv
// Bench for pwd_lock_ctrl: directed scenarios plus a random run against a queue-based model.
module tb_pwd_lock_ctrl;

  localparam int          DIGIT_W = 8;
  localparam int          N       = 3;
  localparam int          MAX     = 3;
  localparam int          LOCK    = 60;
  localparam int          TICK_W  = 8;
  localparam logic [23:0] INIT    = 24'h030201;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pwd_lock_ctrl_if #(.DIGIT_W(DIGIT_W), .TICK_W(TICK_W)) bus ();

  pwd_lock_ctrl #(
    .DIGIT_W    (DIGIT_W),
    .N_DIGITS   (N),
    .MAX_TRIES  (MAX),
    .LOCK_TICKS (LOCK),
    .TICK_W     (TICK_W),
    .INIT_PW    (INIT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference model: stored password and the digits of the current attempt as queues.
  int                 m_st, m_fails, m_remain;
  bit                 m_err, m_chg;
  logic [DIGIT_W-1:0] m_pw[$];
  logic [DIGIT_W-1:0] exp_q[$];
  int                 n_checks = 0;
  int                 n_pass   = 0;

  function automatic int exp_cnt();
    return (exp_q.size() > 15) ? 15 : exp_q.size();
  endfunction

  function automatic bit seq_match();
    if (exp_q.size() != m_pw.size()) return 1'b0;
    foreach (exp_q[i]) if (exp_q[i] != m_pw[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    logic [23:0] v;
    v = INIT;
    m_st = 0; m_fails = 0; m_remain = 0; m_err = 0; m_chg = 0;
    m_pw.delete();
    exp_q.delete();
    for (int i = 0; i < N; i++) m_pw.push_back(v[i*8 +: 8]);
  endtask

  task automatic model_step(input bit s, ck, ex, sp, dv, input logic [7:0] d, input bit tk);
    bit e_ck, e_sp, e_dv;
    e_ck = ck && !ex;
    e_sp = sp && !ex && !ck;
    e_dv = dv && !ex && !ck && !sp;
    m_err = 0; m_chg = 0;
    case (m_st)
      0: if (s) m_st = 1;
      1: begin
        if (e_ck) begin
          if (seq_match()) begin
            m_st = 3; m_fails = 0;
          end else begin
            m_err = 1; m_fails++;
            if (m_fails == MAX) begin m_st = 2; m_remain = LOCK; end
          end
          exp_q.delete();
        end else if (e_dv) exp_q.push_back(d);
      end
      2: if (tk) begin
        m_remain--;
        if (m_remain == 0) begin m_st = 1; m_fails = 0; end
      end
      3: begin
        if (ex) begin m_st = 1; exp_q.delete(); end
        else if (e_sp) begin m_st = 4; exp_q.delete(); end
      end
      4: begin
        if (ex) begin m_st = 3; exp_q.delete(); end
        else if (e_ck) begin
          if (exp_q.size() == N) begin m_pw = exp_q; m_chg = 1; m_st = 3; end
          else m_err = 1;
          exp_q.delete();
        end else if (e_dv) exp_q.push_back(d);
      end
      default: ;
    endcase
  endtask

  // Driver: inputs change 1 time unit after a rising edge, outputs are sampled there too.
  task automatic drive(input bit s, ck, ex, sp, dv, input logic [7:0] d, input bit tk);
    bus.cmd_start = s; bus.cmd_check = ck; bus.cmd_exit = ex; bus.cmd_setpw = sp;
    bus.digit_vld = dv; bus.digit = d; bus.tick = tk;
    @(posedge clk);
    model_step(s, ck, ex, sp, dv, d, tk);
    #1;
    bus.cmd_start = 0; bus.cmd_check = 0; bus.cmd_exit = 0; bus.cmd_setpw = 0;
    bus.digit_vld = 0; bus.digit = '0; bus.tick = 0;
  endtask

  task automatic dig(input logic [7:0] d);
    drive(0, 0, 0, 0, 1, d, 0);
  endtask

  task automatic chk();
    drive(0, 1, 0, 0, 0, 8'h00, 0);
  endtask

  task automatic enter_pw(input logic [23:0] pw);
    for (int i = 0; i < 3; i++) dig(pw[i*8 +: 8]);
    chk();
  endtask

  task automatic fail_attempt();
    int n;
    n = $urandom_range(0, 5);
    for (int i = 0; i < n; i++) dig((i == 0) ? 8'hFF : 8'($urandom_range(0, 255)));
    chk();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.tick = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.tick = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (bus.state !== 3'd0) $display("FAIL reset_state: got %0d want 0", bus.state); else n_pass++;
    n_checks++; if (bus.unlocked !== 1'b0) $display("FAIL reset_unlocked: got %0b want 0", bus.unlocked); else n_pass++;
    n_checks++; if (bus.tries_left !== 4'd3) $display("FAIL reset_tries: got %0d want 3", bus.tries_left); else n_pass++;
    n_checks++; if (bus.lock_remain !== 8'd0) $display("FAIL reset_remain: got %0d want 0", bus.lock_remain); else n_pass++;
    n_checks++; if (bus.entry_cnt !== 4'd0) $display("FAIL reset_entry: got %0d want 0", bus.entry_cnt); else n_pass++;
    n_checks++; if ({bus.err_pulse, bus.pw_changed} !== 2'b00) $display("FAIL reset_pulses: got %b want 00", {bus.err_pulse, bus.pw_changed}); else n_pass++;
    for (int i = 0; i < 4; i++) drive(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1, 8'($urandom_range(0, 255)), 1);
    n_checks++; if (bus.state !== 3'd0) $display("FAIL idle_ignores: got %0d want 0", bus.state); else n_pass++;
  endtask

  task automatic test_unlock();
    drive(1, 0, 0, 0, 0, 8'h00, 0);
    n_checks++; if (bus.state !== 3'd1) $display("FAIL start_state: got %0d want 1", bus.state); else n_pass++;
    enter_pw(INIT);
    n_checks++; if (bus.state !== 3'(m_st)) $display("FAIL unlock_state: got %0d want %0d", bus.state, m_st); else n_pass++;
    n_checks++; if (bus.unlocked !== 1'b1) $display("FAIL unlock_flag: got %0b want 1", bus.unlocked); else n_pass++;
    n_checks++; if (bus.tries_left !== 4'd3) $display("FAIL unlock_tries: got %0d want 3", bus.tries_left); else n_pass++;
    n_checks++; if (bus.err_pulse !== 1'b0) $display("FAIL unlock_err: got %0b want 0", bus.err_pulse); else n_pass++;
    drive(0, 0, 1, 0, 0, 8'h00, 0);
  endtask

  task automatic test_wrong_digits();
    dig(8'h01); dig(8'h09); dig(8'h03);
    n_checks++; if (bus.entry_cnt !== 4'd3) $display("FAIL wrong_entry_before: got %0d want 3", bus.entry_cnt); else n_pass++;
    chk();
    n_checks++; if (bus.err_pulse !== 1'b1) $display("FAIL wrong_err: got %0b want 1", bus.err_pulse); else n_pass++;
    n_checks++; if (bus.tries_left !== 4'd2) $display("FAIL wrong_tries: got %0d want 2", bus.tries_left); else n_pass++;
    n_checks++; if (bus.state !== 3'd1) $display("FAIL wrong_state: got %0d want 1", bus.state); else n_pass++;
    n_checks++; if (bus.entry_cnt !== 4'd0) $display("FAIL wrong_entry_after: got %0d want 0", bus.entry_cnt); else n_pass++;
    drive(0, 0, 0, 0, 0, 8'h00, 0);
    n_checks++; if (bus.err_pulse !== 1'b0) $display("FAIL err_one_cycle: got %0b want 0", bus.err_pulse); else n_pass++;
    dig(8'h01); dig(8'h02); dig(8'h03); dig(8'h01);
    chk();
    n_checks++; if (bus.state !== 3'(m_st) || bus.err_pulse !== 1'b1) $display("FAIL four_digits: got state %0d err %0b want %0d 1", bus.state, bus.err_pulse, m_st); else n_pass++;
    chk();
    n_checks++; if (bus.state !== 3'd2 || bus.err_pulse !== 1'b1) $display("FAIL empty_check: got state %0d err %0b want 2 1", bus.state, bus.err_pulse); else n_pass++;
  endtask

  task automatic test_lockout();
    n_checks++; if (bus.lock_remain !== 8'(LOCK)) $display("FAIL lockout_load: got %0d want %0d", bus.lock_remain, LOCK); else n_pass++;
    n_checks++; if (bus.tries_left !== 4'd0) $display("FAIL lockout_tries: got %0d want 0", bus.tries_left); else n_pass++;
    for (int t = 0; t < LOCK - 1; t++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) drive(0, 1'($urandom_range(0, 1)), 0, 0, 1, 8'($urandom_range(0, 255)), 0);
      drive(0, 0, 0, 0, 0, 8'h00, 1);
      n_checks++; if (bus.lock_remain !== 8'(m_remain)) $display("FAIL lockout_count: got %0d want %0d", bus.lock_remain, m_remain); else n_pass++;
    end
    n_checks++; if (bus.state !== 3'd2 || bus.lock_remain !== 8'd1) $display("FAIL lockout_59: got state %0d remain %0d want 2 1", bus.state, bus.lock_remain); else n_pass++;
    drive(0, 0, 0, 0, 0, 8'h00, 1);
    n_checks++; if (bus.state !== 3'd1 || bus.tries_left !== 4'd3 || bus.lock_remain !== 8'd0) $display("FAIL lockout_end: got state %0d tries %0d remain %0d want 1 3 0", bus.state, bus.tries_left, bus.lock_remain); else n_pass++;
  endtask

  task automatic test_setpw();
    enter_pw(INIT);
    drive(0, 0, 0, 1, 0, 8'h00, 0);
    n_checks++; if (bus.state !== 3'd4 || bus.unlocked !== 1'b1) $display("FAIL setpw_enter: got state %0d unl %0b want 4 1", bus.state, bus.unlocked); else n_pass++;
    dig(8'h0A); dig(8'h0B); dig(8'h0C);
    chk();
    n_checks++; if (bus.pw_changed !== 1'b1 || bus.state !== 3'd3) $display("FAIL setpw_commit: got chg %0b state %0d want 1 3", bus.pw_changed, bus.state); else n_pass++;
    drive(0, 0, 1, 0, 0, 8'h00, 0);
    enter_pw(INIT);
    n_checks++; if (bus.err_pulse !== 1'b1 || bus.state !== 3'd1) $display("FAIL old_pw_rejected: got err %0b state %0d want 1 1", bus.err_pulse, bus.state); else n_pass++;
    enter_pw(24'h0C0B0A);
    n_checks++; if (bus.state !== 3'd3 || bus.tries_left !== 4'd3) $display("FAIL new_pw_accepted: got state %0d tries %0d want 3 3", bus.state, bus.tries_left); else n_pass++;
  endtask

  task automatic test_setpw_short();
    drive(0, 0, 0, 1, 0, 8'h00, 0);
    dig(8'h55); dig(8'h66);
    chk();
    n_checks++; if (bus.err_pulse !== 1'b1 || bus.state !== 3'd4 || bus.entry_cnt !== 4'd0) $display("FAIL setpw_short: got err %0b state %0d cnt %0d want 1 4 0", bus.err_pulse, bus.state, bus.entry_cnt); else n_pass++;
    dig(8'h11); dig(8'h22); dig(8'h33); dig(8'h44);
    chk();
    n_checks++; if (bus.err_pulse !== 1'b1 || bus.pw_changed !== 1'b0 || bus.state !== 3'd4) $display("FAIL setpw_over: got err %0b chg %0b state %0d want 1 0 4", bus.err_pulse, bus.pw_changed, bus.state); else n_pass++;
    dig(8'h77); dig(8'h78); dig(8'h79);
    drive(0, 0, 1, 0, 0, 8'h00, 0);
    n_checks++; if (bus.state !== 3'd3 || bus.pw_changed !== 1'b0) $display("FAIL setpw_abort: got state %0d chg %0b want 3 0", bus.state, bus.pw_changed); else n_pass++;
    drive(0, 0, 1, 0, 0, 8'h00, 0);
    enter_pw(24'h0C0B0A);
    n_checks++; if (bus.state !== 3'd3) $display("FAIL pw_unchanged: got %0d want 3", bus.state); else n_pass++;
    drive(0, 0, 1, 0, 0, 8'h00, 0);
  endtask

  task automatic test_rst_mid();
    for (int i = 0; i < MAX; i++) fail_attempt();
    for (int t = 0; t < 30; t++) drive(0, 0, 0, 0, 0, 8'h00, 1);
    n_checks++; if (bus.lock_remain !== 8'd30 || bus.state !== 3'd2) $display("FAIL mid_lockout: got remain %0d state %0d want 30 2", bus.lock_remain, bus.state); else n_pass++;
    do_reset();
    n_checks++; if (bus.state !== 3'd0 || bus.lock_remain !== 8'd0 || bus.tries_left !== 4'd3) $display("FAIL rst_mid: got state %0d remain %0d tries %0d want 0 0 3", bus.state, bus.lock_remain, bus.tries_left); else n_pass++;
    drive(1, 0, 0, 0, 0, 8'h00, 0);
    dig(8'h01); dig(8'h02);
    drive(0, 1, 0, 0, 1, 8'h03, 0);
    n_checks++; if (bus.err_pulse !== 1'b1 || bus.state !== 3'd1 || bus.entry_cnt !== 4'd0) $display("FAIL digit_dropped: got err %0b state %0d cnt %0d want 1 1 0", bus.err_pulse, bus.state, bus.entry_cnt); else n_pass++;
    enter_pw(INIT);
    n_checks++; if (bus.state !== 3'd3) $display("FAIL init_pw_restored: got %0d want 3", bus.state); else n_pass++;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      bit s, ck, ex, sp, dv, tk;
      logic [7:0] d;
      s  = ($urandom_range(0, 9) == 0);
      ck = ($urandom_range(0, 7) == 0);
      ex = ($urandom_range(0, 19) == 0);
      sp = ($urandom_range(0, 11) == 0);
      dv = 1'($urandom_range(0, 1));
      tk = ($urandom_range(0, 2) == 0);
      if (exp_q.size() < N && $urandom_range(0, 3) != 0) d = m_pw[exp_q.size()];
      else d = 8'($urandom_range(0, 255));
      drive(s, ck, ex, sp, dv, d, tk);
      n_checks++; if (bus.state !== 3'(m_st)) $display("FAIL rnd_state: cyc %0d got %0d want %0d", c, bus.state, m_st); else n_pass++;
      n_checks++; if (bus.unlocked !== (m_st == 3 || m_st == 4)) $display("FAIL rnd_unlocked: cyc %0d got %0b", c, bus.unlocked); else n_pass++;
      n_checks++; if (bus.entry_cnt !== 4'(exp_cnt())) $display("FAIL rnd_entry: cyc %0d got %0d want %0d", c, bus.entry_cnt, exp_cnt()); else n_pass++;
      n_checks++; if (bus.tries_left !== 4'(MAX - m_fails)) $display("FAIL rnd_tries: cyc %0d got %0d want %0d", c, bus.tries_left, MAX - m_fails); else n_pass++;
      n_checks++; if (bus.lock_remain !== 8'(m_remain)) $display("FAIL rnd_remain: cyc %0d got %0d want %0d", c, bus.lock_remain, m_remain); else n_pass++;
      n_checks++; if (bus.err_pulse !== m_err) $display("FAIL rnd_err: cyc %0d got %0b want %0b", c, bus.err_pulse, m_err); else n_pass++;
      n_checks++; if (bus.pw_changed !== m_chg) $display("FAIL rnd_chg: cyc %0d got %0b want %0b", c, bus.pw_changed, m_chg); else n_pass++;
    end
  endtask

  initial begin
    rst = 1'b0;
    bus.cmd_start = 0; bus.cmd_check = 0; bus.cmd_exit = 0; bus.cmd_setpw = 0;
    bus.digit_vld = 0; bus.digit = '0; bus.tick = 0;
    @(posedge clk);
    #1;
    test_reset();
    test_unlock();
    test_wrong_digits();
    test_lockout();
    test_setpw();
    test_setpw_short();
    test_rst_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
